// File: rtl/vc_crossbar4_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vc_xbar_alloc_pkg
// Brief    : Shared constants and types for the 4x4 crossbar switch allocator.
// Revision : 1.0
// ============================================================================
package vc_xbar_alloc_pkg;

  localparam int NPORTS = 4;
  localparam int SELW   = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SELW-1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/vc_crossbar4_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_crossbar4_alloc_if
// Brief    : Beat-level val/rdy, routing and crossbar select bundle of the allocator.
// Revision : 1.0
// ============================================================================
interface vc_crossbar4_alloc_if;
  import vc_xbar_alloc_pkg::*;

  logic [NPORTS-1:0]      in_val;
  logic [NPORTS-1:0]      in_last;
  logic [SELW*NPORTS-1:0] in_dest;
  logic [NPORTS-1:0]      in_dom;
  logic [NPORTS-1:0]      out_dom;
  logic [NPORTS-1:0]      out_rdy;
  logic [NPORTS-1:0]      in_rdy;
  logic [NPORTS-1:0]      out_val;
  port_idx_t              sel0;
  port_idx_t              sel1;
  port_idx_t              sel2;
  port_idx_t              sel3;
  logic [NPORTS-1:0]      in_err;

  // Allocator side
  modport master (
    input  in_val, in_last, in_dest, in_dom, out_dom, out_rdy,
    output in_rdy, out_val, sel0, sel1, sel2, sel3, in_err
  );

  // Traffic / crossbar side
  modport slave (
    output in_val, in_last, in_dest, in_dom, out_dom, out_rdy,
    input  in_rdy, out_val, sel0, sel1, sel2, sel3, in_err
  );

endinterface
`default_nettype wire

// File: rtl/vc_crossbar4_alloc_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : vc_rr_arb4
// Brief    : Combinational 4-way round-robin pick: first requester at or after ptr.
// Revision : 1.0
// ============================================================================
module vc_rr_arb4
  import vc_xbar_alloc_pkg::*;
(
  input  wire logic [NPORTS-1:0] i_req,
  input  wire port_idx_t         i_ptr,
  output logic      [NPORTS-1:0] o_gnt,
  output port_idx_t              o_idx,
  output logic                   o_any
);

  port_idx_t w_cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = i_ptr;
    o_any  = 1'b0;
    w_cand = i_ptr;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      w_cand = i_ptr + port_idx_t'(k);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_crossbar4_alloc.sv
`default_nettype none
// ============================================================================
// Module   : vc_crossbar4_alloc
// Brief    : 4x4 crossbar switch allocator, per-output round-robin with wormhole lock.
//            XBAR_DOMAIN_ISOLATE_EN: block and drain H-domain packets bound for L outputs.
// Revision : 1.0
// ============================================================================
module vc_crossbar4_alloc
  import vc_xbar_alloc_pkg::*;
#(
  parameter bit        P_PKT_LOCK = 1'b1,
  parameter port_idx_t P_RR_INIT  = 2'd0
) (
  input  wire logic           clk,
  input  wire logic           reset,
  vc_crossbar4_alloc_if.master xb
);

  state_t    r_state [NPORTS];
  port_idx_t r_owner [NPORTS];
  port_idx_t r_ptr   [NPORTS];

  state_t    w_state_nxt [NPORTS];
  port_idx_t w_owner_nxt [NPORTS];
  port_idx_t w_ptr_nxt   [NPORTS];

  port_idx_t         w_dest [NPORTS];
  logic [NPORTS-1:0] w_req  [NPORTS];
  logic [NPORTS-1:0] w_unused_gnt [NPORTS];
  port_idx_t         w_gidx [NPORTS];
  logic [NPORTS-1:0] w_any;

  logic [NPORTS-1:0] w_blocked;
  logic [NPORTS-1:0] w_out_val;
  logic [NPORTS-1:0] w_in_rdy;
  logic [NPORTS-1:0] w_xfer;
  logic [NPORTS-1:0] w_release;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      w_dest[i] = xb.in_dest[SELW*i +: SELW];
    end
  end

`ifdef XBAR_DOMAIN_ISOLATE_EN
  // An H input aimed at an L output never requests; its packet is drained instead.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_blocked[i] = xb.in_dom[i] && !xb.out_dom[w_dest[i]];
    end
  end
`else
  logic w_unused_dom;
  assign w_unused_dom = ^{xb.in_dom, xb.out_dom};
  assign w_blocked    = '0;
`endif

  // w_req is indexed [output][input]
  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        w_req[j][i] = xb.in_val[i] && (w_dest[i] == port_idx_t'(j)) && !w_blocked[i];
      end
    end
  end

  generate
    for (genvar j = 0; j < NPORTS; j++) begin : g_arb
      vc_rr_arb4 u_arb (
        .i_req (w_req[j]),
        .i_ptr (r_ptr[j]),
        .o_gnt (w_unused_gnt[j]),
        .o_idx (w_gidx[j]),
        .o_any (w_any[j])
      );
    end
  endgenerate

  // Datapath handshake: a locked output connects its owner's val/rdy straight through.
  always_comb begin
    w_out_val = '0;
    w_in_rdy  = '0;
    w_xfer    = '0;
    w_release = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (r_state[j] == LOCKED) begin
        w_out_val[j]           = xb.in_val[r_owner[j]];
        w_in_rdy[r_owner[j]]   = w_in_rdy[r_owner[j]] | xb.out_rdy[j];
        w_xfer[j]              = xb.in_val[r_owner[j]] && xb.out_rdy[j];
        w_release[j]           = w_xfer[j] && (!P_PKT_LOCK || xb.in_last[r_owner[j]]);
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (w_blocked[i] && xb.in_val[i] && !reset) begin
        w_in_rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      w_state_nxt[j] = r_state[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
      case (r_state[j])
        IDLE: begin
          if (w_any[j]) begin
            w_state_nxt[j] = LOCKED;
            w_owner_nxt[j] = w_gidx[j];
          end
        end
        LOCKED: begin
          // Ex-owner drops to lowest priority on release
          if (w_release[j]) begin
            w_state_nxt[j] = IDLE;
            w_ptr_nxt[j]   = r_owner[j] + port_idx_t'(1);
          end
        end
        default: w_state_nxt[j] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NPORTS; j++) begin
        r_state[j] <= IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= P_RR_INIT;
      end
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        r_state[j] <= w_state_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
      end
    end
  end

`ifdef XBAR_DOMAIN_ISOLATE_EN
  logic [NPORTS-1:0] r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err <= xb.in_val & w_blocked & xb.in_last;
    end
  end

  assign xb.in_err = r_err;
`else
  assign xb.in_err = '0;
`endif

  assign xb.out_val = w_out_val;
  assign xb.in_rdy  = w_in_rdy;
  assign xb.sel0    = r_owner[0];
  assign xb.sel1    = r_owner[1];
  assign xb.sel2    = r_owner[2];
  assign xb.sel3    = r_owner[3];

endmodule
`default_nettype wire

// File: tb/tb_vc_crossbar4_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_crossbar4_alloc
// Brief    : Directed self-checking bench for the 4x4 crossbar switch allocator.
// Revision : 1.0
// ============================================================================
module tb_vc_crossbar4_alloc;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   beats;

  vc_crossbar4_alloc_if xb ();

  vc_crossbar4_alloc dut (
    .clk   (clk),
    .reset (reset),
    .xb    (xb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [7:0] sels();
    return {xb.sel3, xb.sel2, xb.sel1, xb.sel0};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(xb.in_rdy), 32'h0);
    chk({tag, "_val"}, 32'(xb.out_val), 32'h0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    beats   = 0;
    reset      = 1'b1;
    xb.in_val  = '0;
    xb.in_last = '0;
    xb.in_dest = '0;
    xb.in_dom  = '0;
    xb.out_dom = 4'hF;
    xb.out_rdy = 4'hF;

    cyc(); #1;
    chk_idle("reset");
    chk("reset_sel", 32'(sels()), 32'h0);
    chk("reset_err", 32'(xb.in_err), 32'h0);
    cyc(); reset = 1'b0;

    // 1: single beat in0 -> out2
    cyc(); xb.in_val = 4'b0001; xb.in_dest = 8'h02; xb.in_last = 4'b0001; #1;
    chk_idle("t1_idle");
    cyc(); #1;
    chk("t1_rdy", 32'(xb.in_rdy), 32'h1);
    chk("t1_val", 32'(xb.out_val), 32'h4);
    chk("t1_sel2", 32'(xb.sel2), 32'h0);
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;
    chk_idle("t1_done");

    // 2: contention on out1, grants 0..3 then pointer wraps
    cyc(); xb.in_val = 4'hF; xb.in_dest = 8'h55; xb.in_last = 4'hF; #1;
    chk_idle("t2_idle0");
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("t2_rdy", 32'(xb.in_rdy), 32'(1 << k));
      chk("t2_val", 32'(xb.out_val), 32'h2);
      chk("t2_sel1", 32'(xb.sel1), 32'(k));
      cyc(); xb.in_val[k] = 1'b0; #1;
      chk_idle("t2_gap");
      chk("t2_selhold", 32'(xb.sel1), 32'(k));
    end
    cyc(); xb.in_val = 4'b1001; #1;
    chk_idle("t2_wrap_idle");
    cyc(); #1;
    chk("t2_wrap_rdy", 32'(xb.in_rdy), 32'h1);
    chk("t2_wrap_sel", 32'(xb.sel1), 32'h0);
    cyc(); xb.in_val = 4'b1000; #1;
    chk_idle("t2_gap3");
    cyc(); #1;
    chk("t2_in3_rdy", 32'(xb.in_rdy), 32'h8);
    cyc(); xb.in_val = '0; #1;
    chk_idle("t2_done");

    // 3: wormhole in1 3 beats to out0, in3 waiting
    cyc(); xb.in_val = 4'b1010; xb.in_dest = 8'h00; xb.in_last = '0; #1;
    chk_idle("t3_idle");
    for (int b = 0; b < 3; b++) begin
      cyc(); if (b == 2) xb.in_last = 4'b0010; #1;
      chk("t3_rdy", 32'(xb.in_rdy), 32'h2);
      chk("t3_val", 32'(xb.out_val), 32'h1);
      chk("t3_sel0", 32'(xb.sel0), 32'h1);
    end
    cyc(); xb.in_val = 4'b1000; xb.in_last = 4'b1000; #1;
    chk_idle("t3_gap");
    cyc(); #1;
    chk("t3_in3_rdy", 32'(xb.in_rdy), 32'h8);
    chk("t3_in3_sel", 32'(xb.sel0), 32'h3);
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;
    chk_idle("t3_done");

    // 4: backpressure on out3 mid-packet, in2 4 beats
    cyc(); xb.in_val = 4'b0100; xb.in_dest = 8'h30; #1;
    chk_idle("t4_idle");
    cyc(); #1;
    chk("t4_b1_rdy", 32'(xb.in_rdy), 32'h4);
    if (xb.in_rdy[2] && xb.in_val[2]) beats++;
    for (int s = 0; s < 5; s++) begin
      cyc(); xb.out_rdy = 4'b0111; #1;
      chk("t4_stall_rdy", 32'(xb.in_rdy), 32'h0);
      chk("t4_stall_val", 32'(xb.out_val), 32'h8);
      chk("t4_stall_sel", 32'(xb.sel3), 32'h2);
      if (xb.in_rdy[2] && xb.in_val[2]) beats++;
    end
    for (int b = 0; b < 3; b++) begin
      cyc(); xb.out_rdy = 4'hF; if (b == 2) xb.in_last = 4'b0100; #1;
      chk("t4_rdy", 32'(xb.in_rdy), 32'h4);
      if (xb.in_rdy[2] && xb.in_val[2]) beats++;
    end
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;
    chk_idle("t4_done");
    chk("t4_beats", 32'(beats), 32'd4);
    // ptr[3] must now be 3: in3 beats in1
    cyc(); xb.in_val = 4'b1010; xb.in_dest = 8'hCC; xb.in_last = 4'b1010; #1;
    chk_idle("t4_ptr_idle");
    cyc(); #1;
    chk("t4_ptr_rdy", 32'(xb.in_rdy), 32'h8);
    chk("t4_ptr_sel", 32'(xb.sel3), 32'h3);
    cyc(); xb.in_val = 4'b0010; #1;
    chk_idle("t4_gap");
    cyc(); #1;
    chk("t4_in1_rdy", 32'(xb.in_rdy), 32'h2);
    cyc(); xb.in_val = '0; #1;
    chk_idle("t4_done2");

    // 5: async reset mid-packet (in2 -> out1); ptr[3] is 2 beforehand
    cyc(); xb.in_val = 4'b0100; xb.in_dest = 8'h10; xb.in_last = '0; #1;
    chk_idle("t5_idle");
    cyc(); #1;
    chk("t5_rdy", 32'(xb.in_rdy), 32'h4);
    chk("t5_sel1", 32'(xb.sel1), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk_idle("t5_async");
    chk("t5_sel", 32'(sels()), 32'h0);
    cyc(); reset = 1'b0; xb.in_val = 4'b1010; xb.in_dest = 8'hCC; xb.in_last = 4'b1010; #1;
    chk_idle("t5_post");
    cyc(); #1;
    chk("t5_ptr_rdy", 32'(xb.in_rdy), 32'h2);
    chk("t5_ptr_sel", 32'(xb.sel3), 32'h1);
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;

    // 6: H input 2 to L output 0, 2 beats
    cyc(); xb.in_val = 4'b0100; xb.in_dest = 8'h00; xb.in_dom = 4'b0100; xb.out_dom = 4'b1110; #1;
`ifdef XBAR_DOMAIN_ISOLATE_EN
    chk("t6_d1_rdy", 32'(xb.in_rdy), 32'h4);
    chk("t6_d1_val", 32'(xb.out_val), 32'h0);
    cyc(); xb.in_last = 4'b0100; #1;
    chk("t6_d2_rdy", 32'(xb.in_rdy), 32'h4);
    chk("t6_d2_val", 32'(xb.out_val), 32'h0);
    chk("t6_d2_err", 32'(xb.in_err), 32'h0);
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;
    chk("t6_err", 32'(xb.in_err), 32'h4);
    chk("t6_val", 32'(xb.out_val), 32'h0);
    cyc(); #1;
    chk("t6_err_end", 32'(xb.in_err), 32'h0);
`else
    chk_idle("t6_idle");
    cyc(); #1;
    chk("t6_b1_rdy", 32'(xb.in_rdy), 32'h4);
    chk("t6_b1_val", 32'(xb.out_val), 32'h1);
    cyc(); xb.in_last = 4'b0100; #1;
    chk("t6_b2_rdy", 32'(xb.in_rdy), 32'h4);
    chk("t6_err0", 32'(xb.in_err), 32'h0);
    cyc(); xb.in_val = '0; xb.in_last = '0; #1;
    chk_idle("t6_done");
    chk("t6_err1", 32'(xb.in_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
